// File: rtl/data_mem_stage.sv
// Memory stage of the 3-stage RISC-V core.
// Performs SW / LB against a word-organised data RAM and registers the
// writeback payload (wb_data, wb_rd, wb_we) that feeds the register file.
// A load holds the pipeline via stall for LOAD_LATENCY cycles and retires
// LOAD_LATENCY+1 cycles after acceptance; every other instruction retires
// one cycle after acceptance.
module data_mem_stage #(
  parameter int DEPTH_WORDS  = 256,
  parameter int LOAD_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd_in,
  input  logic        lb,
  input  logic        sw,
  input  logic        lui_control,
  input  logic [31:0] lui_imm_val,
  input  logic        jump,
  output logic        stall,
  output logic        wb_valid,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        misalign_err
);

  localparam int ADDR_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W  = (LOAD_LATENCY > 1) ? $clog2(LOAD_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOAD_LATENCY - 1);

  typedef enum logic {
    IDLE      = 1'b0,
    LOAD_WAIT = 1'b1
  } state_t;

  state_t state, state_nxt;

  // Data RAM, one 32-bit word per entry.
  logic [31:0] mem [DEPTH_WORDS];

  // Address decode of the incoming instruction. Bits above the word index
  // are dropped, so addresses wrap modulo DEPTH_WORDS*4.
  logic [ADDR_W-1:0] in_idx;
  logic [1:0]        in_off;
  assign in_idx = alu_result[ADDR_W+1:2];
  assign in_off = alu_result[1:0];

  // Upper address bits are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^alu_result[31:ADDR_W+2];

  // Outstanding-load context captured at acceptance.
  logic [ADDR_W-1:0] ld_idx;
  logic [1:0]        ld_off;
  logic [4:0]        ld_rd;
  logic [CNT_W-1:0]  wait_cnt;

  // Accept / retire qualifiers.
  logic accept;
  logic accept_load;
  logic load_done;
  assign accept      = (state == IDLE) && valid_in;
  assign accept_load = accept && lb;
  assign load_done   = (state == LOAD_WAIT) && (wait_cnt == CNT_LAST);

  // Next-cycle register values produced by the output logic.
  logic        stall_d;
  logic        wb_valid_d;
  logic        wb_we_d;
  logic [4:0]  wb_rd_d;
  logic [31:0] wb_data_d;
  logic        misalign_set;
  logic        mem_we;

  // Load byte extraction: little-endian byte select and sign extension.
  logic [31:0] ld_word;
  logic [7:0]  ld_byte;
  logic [31:0] ld_sext;
  assign ld_word = mem[ld_idx];

  // Pick the addressed byte out of the stored word.
  always_comb begin
    // NOTE: every signal driven in a combinational block gets a default
    // first, otherwise a missed branch infers a latch.
    ld_byte = ld_word[7:0];
    case (ld_off)
      2'd0: ld_byte = ld_word[7:0];
      2'd1: ld_byte = ld_word[15:8];
      2'd2: ld_byte = ld_word[23:16];
      2'd3: ld_byte = ld_word[31:24];
      default: ld_byte = ld_word[7:0];
    endcase
  end

  assign ld_sext = {{24{ld_byte[7]}}, ld_byte};

  // FSM state register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state logic: a load parks in LOAD_WAIT until its counter expires.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (accept_load) state_nxt = LOAD_WAIT;
      LOAD_WAIT: if (load_done)   state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // FSM output logic: next-cycle writeback payload, store strobe and flags.
  // Flag priority is lb > sw > lui_control > jump > plain ALU result.
  always_comb begin
    stall_d      = (state_nxt == LOAD_WAIT);
    wb_valid_d   = 1'b0;
    wb_we_d      = 1'b0;
    wb_rd_d      = wb_rd;
    wb_data_d    = wb_data;
    misalign_set = 1'b0;
    mem_we       = 1'b0;
    case (state)
      IDLE: begin
        if (valid_in && !lb) begin
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_in;
          wb_data_d  = alu_result;
          if (sw) begin
            // Store still lands at the truncated word address when misaligned.
            mem_we       = 1'b1;
            misalign_set = (in_off != 2'b00);
          end else if (lui_control) begin
            wb_data_d = lui_imm_val;
            wb_we_d   = (rd_in != 5'd0);
          end else if (jump) begin
            wb_we_d = 1'b0;
          end else begin
            wb_we_d = (rd_in != 5'd0);
          end
        end
      end
      LOAD_WAIT: begin
        if (load_done) begin
          wb_valid_d = 1'b1;
          wb_rd_d    = ld_rd;
          wb_data_d  = ld_sext;
          wb_we_d    = (ld_rd != 5'd0);
        end
      end
      default: ;
    endcase
  end

  // Load context capture and LOAD_WAIT cycle counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      ld_idx   <= '0;
      ld_off   <= '0;
      ld_rd    <= '0;
      wait_cnt <= '0;
    end else if (accept_load) begin
      ld_idx   <= in_idx;
      ld_off   <= in_off;
      ld_rd    <= rd_in;
      wait_cnt <= '0;
    end else if (state == LOAD_WAIT) begin
      wait_cnt <= load_done ? '0 : wait_cnt + 1'b1;
    end
  end

  // Data RAM write port; reset clears every word.
  always_ff @(posedge clk) begin
    // NOTE: this RAM is reset to zero, so it maps to flops rather than a
    // RAM macro; drop the reset loop if a macro is ever required.
    if (reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        mem[i] <= '0;
      end
    end else if (mem_we) begin
      mem[in_idx] <= store_data;
    end
  end

  // Registered outputs; misalign_err is sticky until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall        <= 1'b0;
      wb_valid     <= 1'b0;
      wb_we        <= 1'b0;
      wb_rd        <= '0;
      wb_data      <= '0;
      misalign_err <= 1'b0;
    end else begin
      stall        <= stall_d;
      wb_valid     <= wb_valid_d;
      wb_we        <= wb_we_d;
      wb_rd        <= wb_rd_d;
      wb_data      <= wb_data_d;
      misalign_err <= misalign_err | misalign_set;
    end
  end

endmodule

// File: tb/tb_data_mem_stage.sv
// Self-checking bench for data_mem_stage: directed steps followed by random
// instructions, all compared against a behavioural model of the memory stage.
module tb_data_mem_stage;

  localparam int DEPTH = 256;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        valid_in = 1'b0;
  logic [31:0] alu_result = '0;
  logic [31:0] store_data = '0;
  logic [4:0]  rd_in = '0;
  logic        lb = 1'b0;
  logic        sw = 1'b0;
  logic        lui_control = 1'b0;
  logic [31:0] lui_imm_val = '0;
  logic        jump = 1'b0;
  logic        stall;
  logic        wb_valid;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        misalign_err;

  always #5 clk = ~clk;

  data_mem_stage #(
    .DEPTH_WORDS (DEPTH),
    .LOAD_LATENCY(LAT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .valid_in    (valid_in),
    .alu_result  (alu_result),
    .store_data  (store_data),
    .rd_in       (rd_in),
    .lb          (lb),
    .sw          (sw),
    .lui_control (lui_control),
    .lui_imm_val (lui_imm_val),
    .jump        (jump),
    .stall       (stall),
    .wb_valid    (wb_valid),
    .wb_we       (wb_we),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .misalign_err(misalign_err)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state.
  logic [31:0] ref_mem [DEPTH];
  logic        ref_mis;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    ref_mis = 1'b0;
  endtask

  // Architectural effect of one accepted instruction.
  task automatic model_op(input logic lbx, swx, luix, jx, input logic [31:0] addr, sdata, imm,
                          input logic [4:0] rd, output logic exp_we, output logic [31:0] exp_data);
    int unsigned idx;
    int unsigned off;
    logic [7:0]  b;
    idx = (addr / 4) % DEPTH;
    off = addr % 4;
    exp_we   = 1'b0;
    exp_data = addr;
    if (lbx) begin
      b        = 8'((ref_mem[idx] >> (8 * off)) & 32'hFF);
      exp_data = 32'($signed(b));
      exp_we   = (rd != 0);
    end else if (swx) begin
      ref_mem[idx] = sdata;
      if (off != 0) ref_mis = 1'b1;
    end else if (luix) begin
      exp_data = imm;
      exp_we   = (rd != 0);
    end else if (!jx) begin
      exp_we = (rd != 0);
    end
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    valid_in = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    model_clear();
  endtask

  // Present one instruction at a negedge and check its retirement.
  task automatic run_op(input string tag, input logic v, lbx, swx, luix, jx,
                        input logic [31:0] addr, sdata, imm, input logic [4:0] rd);
    logic        exp_we;
    logic [31:0] exp_data;
    int          n;
    exp_we   = 1'b0;
    exp_data = '0;
    if (v) model_op(lbx, swx, luix, jx, addr, sdata, imm, rd, exp_we, exp_data);
    valid_in = v; lb = lbx; sw = swx; lui_control = luix; jump = jx;
    alu_result = addr; store_data = sdata; lui_imm_val = imm; rd_in = rd;
    @(posedge clk);
    @(negedge clk);
    if (!v) begin
      check({tag, "_idle_valid"}, 32'(wb_valid), 32'd0);
      check({tag, "_idle_we"}, 32'(wb_we), 32'd0);
      check({tag, "_idle_stall"}, 32'(stall), 32'd0);
    end else if (lbx) begin
      check({tag, "_stall_on"}, 32'(stall), 32'd1);
      check({tag, "_valid_early"}, 32'(wb_valid), 32'd0);
      n = 1;
      while (stall === 1'b1 && n < 20) begin
        @(negedge clk);
        if (stall === 1'b1) n++;
      end
      check({tag, "_stall_cycles"}, 32'(n), 32'(LAT));
      check({tag, "_valid"}, 32'(wb_valid), 32'd1);
      check({tag, "_we"}, 32'(wb_we), 32'(exp_we));
      check({tag, "_rd"}, 32'(wb_rd), 32'(rd));
      check({tag, "_data"}, wb_data, exp_data);
    end else begin
      check({tag, "_stall"}, 32'(stall), 32'd0);
      check({tag, "_valid"}, 32'(wb_valid), 32'd1);
      check({tag, "_we"}, 32'(wb_we), 32'(exp_we));
      check({tag, "_rd"}, 32'(wb_rd), 32'(rd));
      if (!swx) check({tag, "_data"}, wb_data, exp_data);
    end
    check({tag, "_misalign"}, 32'(misalign_err), 32'(ref_mis));
  endtask

  initial begin
    logic       rv, rl, rs, ru, rj;
    logic [31:0] ra;

    // Reset state.
    reset_dut();
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_valid", 32'(wb_valid), 32'd0);
    check("rst_we", 32'(wb_we), 32'd0);
    check("rst_rd", 32'(wb_rd), 32'd0);
    check("rst_data", wb_data, 32'd0);
    check("rst_misalign", 32'(misalign_err), 32'd0);
    run_op("rst_lb", 1, 1, 0, 0, 0, 32'h0000_0010, 0, 0, 5'd1);

    // Store, then byte loads from the stored word, including address wrap.
    run_op("sw_10", 1, 0, 1, 0, 0, 32'h0000_0010, 32'h8081_7F01, 0, 5'd7);
    run_op("lb_13", 1, 1, 0, 0, 0, 32'h0000_0013, 0, 0, 5'd5);
    run_op("lb_11", 1, 1, 0, 0, 0, 32'h0000_0011, 0, 0, 5'd6);
    run_op("lb_410", 1, 1, 0, 0, 0, 32'h0000_0410, 0, 0, 5'd8);
    run_op("lb_12_rd0", 1, 1, 0, 0, 0, 32'h0000_0012, 0, 0, 5'd0);

    // ALU writeback and x0 suppression.
    run_op("add_rd3", 1, 0, 0, 0, 0, 32'd42, 0, 0, 5'd3);
    run_op("add_rd0", 1, 0, 0, 0, 0, 32'd42, 0, 0, 5'd0);
    run_op("idle", 0, 0, 0, 0, 0, 0, 0, 0, 5'd0);

    // Priority: lb over lui, lui alone, jump.
    run_op("lui_lb", 1, 1, 0, 1, 0, 32'h0000_0012, 0, 32'h1234_5000, 5'd9);
    run_op("lui", 1, 0, 0, 1, 0, 32'h0000_0012, 0, 32'h1234_5000, 5'd9);
    run_op("sw_lui", 1, 0, 1, 1, 0, 32'h0000_0020, 32'hCAFE_F00D, 32'h1, 5'd4);
    run_op("jump", 1, 0, 0, 0, 1, 32'h0000_0400, 0, 0, 5'd1);
    run_op("lb_23", 1, 1, 0, 0, 0, 32'h0000_0023, 0, 0, 5'd2);

    // Random traffic concentrated on a handful of words.
    for (int k = 0; k < 300; k++) begin
      rv = ($urandom_range(0, 7) != 0);
      rl = ($urandom_range(0, 3) == 0);
      rs = ($urandom_range(0, 2) == 0);
      ru = ($urandom_range(0, 3) == 0);
      rj = ($urandom_range(0, 3) == 0);
      ra = $urandom;
      if ($urandom_range(0, 1) == 1) ra = ra & 32'h0000_001F;
      if (rs && $urandom_range(0, 7) != 0) ra = ra & 32'hFFFF_FFFC;
      run_op("rnd", rv, rl, rs, ru, rj, ra, $urandom, $urandom, 5'($urandom_range(0, 31)));
    end

    // Read back every byte of the focus words.
    for (int w = 0; w < 8; w++) begin
      for (int b = 0; b < 4; b++) begin
        run_op("readback", 1, 1, 0, 0, 0, 32'(w * 4 + b), 0, 0, 5'd10);
      end
    end

    // Misaligned store: sticky flag, store lands at the truncated word.
    reset_dut();
    run_op("sw_22", 1, 0, 1, 0, 0, 32'h0000_0022, 32'h0000_00A5, 0, 5'd0);
    run_op("lb_20", 1, 1, 0, 0, 0, 32'h0000_0020, 0, 0, 5'd11);
    run_op("add_after_mis", 1, 0, 0, 0, 0, 32'd7, 0, 0, 5'd12);
    run_op("idle_after_mis", 0, 0, 0, 0, 0, 0, 0, 0, 5'd0);

    // Reset asserted during LOAD_WAIT.
    valid_in = 1'b1; lb = 1'b1; sw = 1'b0; lui_control = 1'b0; jump = 1'b0;
    alu_result = 32'h0000_0020; rd_in = 5'd13;
    @(posedge clk);
    @(negedge clk);
    check("midrst_stall_on", 32'(stall), 32'd1);
    reset = 1'b1;
    valid_in = 1'b0;
    lb = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_stall_off", 32'(stall), 32'd0);
    check("midrst_valid", 32'(wb_valid), 32'd0);
    check("midrst_misalign", 32'(misalign_err), 32'd0);
    reset = 1'b0;
    model_clear();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("midrst_no_wb", 32'(wb_valid), 32'd0);
      check("midrst_no_stall", 32'(stall), 32'd0);
    end
    run_op("lb_cleared", 1, 1, 0, 0, 0, 32'h0000_0020, 0, 0, 5'd14);

    valid_in = 1'b0;
    lb = 1'b0;
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
